// File: rtl/rc6_pkg.sv
// Shared constants and types for the RC6 rotate pipeline.
package rc6_pkg;

  localparam int unsigned RC6_W = 32;

  typedef logic rot_dir_t;

  localparam rot_dir_t ROT_LEFT  = 1'b0;
  localparam rot_dir_t ROT_RIGHT = 1'b1;

endpackage

// File: rtl/rc6_rot_pipe_if.sv
// Valid/ready bus for rc6_rot_pipe; tag sideband present only with RC6_ROT_TAG_EN.
interface rc6_rot_pipe_if
  import rc6_pkg::*;
#(
  parameter int unsigned W = RC6_W
`ifdef RC6_ROT_TAG_EN
  ,
  parameter int unsigned TAG_W = 8
`endif
);
  localparam int unsigned AMT_W = $clog2(W);

  logic             in_valid;
  logic             in_ready;
  rot_dir_t         in_dir;
  logic [AMT_W-1:0] in_amt;
  logic [W-1:0]     in_data;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;
`ifdef RC6_ROT_TAG_EN
  logic [TAG_W-1:0] tag_in;
  logic [TAG_W-1:0] tag_out;

  modport master (
    output in_valid, in_dir, in_amt, in_data, out_ready, tag_in,
    input  in_ready, out_valid, out_data, tag_out
  );
  modport slave (
    input  in_valid, in_dir, in_amt, in_data, out_ready, tag_in,
    output in_ready, out_valid, out_data, tag_out
  );
`else
  modport master (
    output in_valid, in_dir, in_amt, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
  modport slave (
    input  in_valid, in_dir, in_amt, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
`endif

endinterface

// File: rtl/rc6_rot_stage.sv
// One rotator stage: conditionally rotates by the fixed SHIFT in either direction.
module rc6_rot_stage
  import rc6_pkg::*;
#(
  parameter int unsigned W     = RC6_W,
  parameter int unsigned SHIFT = 1
) (
  input  logic         en,
  input  rot_dir_t     dir,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  always_comb begin
    dout = din;
    if (en) begin
      if (dir == ROT_LEFT) dout = {din[W-1-SHIFT:0], din[W-1:W-SHIFT]};
      else                 dout = {din[SHIFT-1:0], din[W-1:SHIFT]};
    end
  end

endmodule

// File: rtl/rc6_rot_pipe.sv
// Pipelined left/right barrel rotator with bubble-collapsing valid/ready handshake.
// Optional tag sideband enabled by defining RC6_ROT_TAG_EN.
module rc6_rot_pipe
  import rc6_pkg::*;
#(
  parameter int unsigned W         = RC6_W,
  parameter int unsigned REG_EVERY = 1
`ifdef RC6_ROT_TAG_EN
  ,
  parameter int unsigned TAG_W     = 8
`endif
) (
  input logic           clk,
  input logic           rst_n,
  rc6_rot_pipe_if.slave bus
);

  localparam int unsigned AMT_W = $clog2(W);
  localparam int unsigned NREG  = (AMT_W + REG_EVERY - 1) / REG_EVERY;

  logic [NREG-1:0]  v_q;
  logic [W-1:0]     d_q   [NREG];
  logic [AMT_W-1:0] a_q   [NREG];
  rot_dir_t         dir_q [NREG];
  logic [W-1:0]     d_n   [NREG];
  logic [NREG:0]    load;
`ifdef RC6_ROT_TAG_EN
  logic [TAG_W-1:0] tag_q [NREG];
`endif

  // Rotation stages; each register group starts from the previous register's contents.
  for (genvar k = 0; k < AMT_W; k++) begin : g_st
    localparam int unsigned R = k / REG_EVERY;
    logic         en;
    rot_dir_t     dir;
    logic [W-1:0] din;
    logic [W-1:0] dout;

    if (R == 0) begin : g_src_in
      assign en  = bus.in_amt[k];
      assign dir = bus.in_dir;
    end else begin : g_src_reg
      assign en  = a_q[R-1][k];
      assign dir = dir_q[R-1];
    end

    if (k % REG_EVERY != 0) begin : g_chain
      assign din = g_st[k-1].dout;
    end else if (R == 0) begin : g_head_in
      assign din = bus.in_data;
    end else begin : g_head_reg
      assign din = d_q[R-1];
    end

    rc6_rot_stage #(.W(W), .SHIFT(2 ** k)) u_stage (
      .en  (en),
      .dir (dir),
      .din (din),
      .dout(dout)
    );
  end

  for (genvar r = 0; r < NREG; r++) begin : g_reg
    localparam int unsigned LAST =
      (((r + 1) * REG_EVERY < AMT_W) ? (r + 1) * REG_EVERY : AMT_W) - 1;
    assign d_n[r] = g_st[LAST].dout;
  end

  // A stage loads when empty or when its successor loads; the tail follows out_ready.
  always_comb begin
    load       = '0;
    load[NREG] = bus.out_ready;
    for (int i = int'(NREG) - 1; i >= 0; i--) begin
      load[i] = !v_q[i] || load[i+1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      for (int r = 0; r < int'(NREG); r++) begin
        d_q[r]   <= '0;
        a_q[r]   <= '0;
        dir_q[r] <= ROT_LEFT;
`ifdef RC6_ROT_TAG_EN
        tag_q[r] <= '0;
`endif
      end
    end else begin
      if (load[0]) begin
        v_q[0]   <= bus.in_valid;
        d_q[0]   <= d_n[0];
        a_q[0]   <= bus.in_amt;
        dir_q[0] <= bus.in_dir;
`ifdef RC6_ROT_TAG_EN
        tag_q[0] <= bus.tag_in;
`endif
      end
      for (int r = 1; r < int'(NREG); r++) begin
        if (load[r]) begin
          v_q[r]   <= v_q[r-1];
          d_q[r]   <= d_n[r];
          a_q[r]   <= a_q[r-1];
          dir_q[r] <= dir_q[r-1];
`ifdef RC6_ROT_TAG_EN
          tag_q[r] <= tag_q[r-1];
`endif
        end
      end
    end
  end

  assign bus.in_ready  = load[0];
  assign bus.out_valid = v_q[NREG-1];
  assign bus.out_data  = d_q[NREG-1];
`ifdef RC6_ROT_TAG_EN
  assign bus.tag_out   = tag_q[NREG-1];
`endif

endmodule

// File: tb/tb_rc6_rot_pipe.sv
// Directed and scoreboard checks for rc6_rot_pipe (W=32 pipeline plus a W=8 single-register build).
module tb_rc6_rot_pipe;
  import rc6_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rc6_rot_pipe_if #(.W(32)) bus ();
  rc6_rot_pipe #(.W(32), .REG_EVERY(1)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  rc6_rot_pipe_if #(.W(8)) bus8 ();
  rc6_rot_pipe #(.W(8), .REG_EVERY(3)) dut8 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus8)
  );

  int          n_vec = 0;
  int          n_err = 0;
  int          n_out = 0;
  int          n_acc = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_rotl(input logic [31:0] x, input int s);
    return (s == 0) ? x : ((x << s) | (x >> (32 - s)));
  endfunction

  function automatic logic [31:0] ref_rotr(input logic [31:0] x, input int s);
    return (s == 0) ? x : ((x >> s) | (x << (32 - s)));
  endfunction

  // Drive one cycle from a negedge; score the output and record any accept.
  task automatic cycle(input logic v, input rot_dir_t dir, input logic [4:0] amt,
                       input logic [31:0] data, input logic ordy, input logic [31:0] exp_val);
    bus.in_valid  = v;
    bus.in_dir    = dir;
    bus.in_amt    = amt;
    bus.in_data   = data;
    bus.out_ready = ordy;
    #1;
    if (bus.out_valid && bus.out_ready) begin
      n_out++;
      if (exp_q.size() == 0) check("extra_word", 32'(exp_q.size()), 32'd1);
      else check("data", bus.out_data, exp_q.pop_front());
    end
    if (v && bus.in_ready) begin
      exp_q.push_back(exp_val);
      n_acc++;
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, ROT_LEFT, 5'd0, 32'd0, ordy, 32'd0);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) idle(1'b1);
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic rand_word(input logic v, input logic ordy);
    logic [31:0] d;
    logic [4:0]  a;
    rot_dir_t    dr;
    d  = $urandom;
    a  = 5'($urandom_range(0, 31));
    dr = 1'($urandom_range(0, 1));
    cycle(v, dr, a, d, ordy, (dr == ROT_RIGHT) ? ref_rotr(d, int'(a)) : ref_rotl(d, int'(a)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          lat;
    logic        pulse_seen;
    logic [31:0] snap;

    bus.in_valid   = 1'b0;
    bus.in_dir     = ROT_LEFT;
    bus.in_amt     = '0;
    bus.in_data    = '0;
    bus.out_ready  = 1'b0;
    bus8.in_valid  = 1'b0;
    bus8.in_dir    = ROT_LEFT;
    bus8.in_amt    = '0;
    bus8.in_data   = '0;
    bus8.out_ready = 1'b1;
`ifdef RC6_ROT_TAG_EN
    bus8.tag_in    = '0;
`endif

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", bus.out_data, 32'd0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);

    // Latency and single-cycle valid pulse
    cycle(1'b1, ROT_LEFT, 5'd1, 32'h8000_0001, 1'b1, 32'h0000_0003);
    lat = 0;
    pulse_seen = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      if (lat == 0 && bus.out_valid) lat = i;
      if (i == 6) pulse_seen = bus.out_valid;
      idle(1'b1);
    end
    check("latency", 32'(lat), 32'd5);
    check("valid_pulse_off", 32'(pulse_seen), 32'd0);

    // Directed vectors, back to back
    cycle(1'b1, ROT_RIGHT, 5'd4,  32'h1234_5678, 1'b1, 32'h8123_4567);
    cycle(1'b1, ROT_LEFT,  5'd31, 32'h1234_5678, 1'b1, 32'h091A_2B3C);
    cycle(1'b1, ROT_LEFT,  5'd0,  32'h1234_5678, 1'b1, 32'h1234_5678);
    cycle(1'b1, ROT_RIGHT, 5'd0,  32'h1234_5678, 1'b1, 32'h1234_5678);
    cycle(1'b1, ROT_RIGHT, 5'd31, 32'h1234_5678, 1'b1, 32'h2468_ACF0);
    cycle(1'b1, ROT_LEFT,  5'd16, 32'hDEAD_BEEF, 1'b1, 32'hBEEF_DEAD);
    drain();

    // Streaming at full rate
    n_out = 0;
    n_acc = 0;
    for (int i = 0; i < 100; i++) rand_word(1'b1, 1'b1);
    check("stream_accepts", 32'(n_acc), 32'd100);
    check("stream_rate", 32'(n_out), 32'd95);
    drain();
    check("stream_total", 32'(n_out), 32'd100);

    // Fill, then stall the output
    n_out = 0;
    n_acc = 0;
    snap  = '0;
    for (int i = 1; i <= 10; i++) begin
      if (i == 7) snap = bus.out_data;
      rand_word(1'b1, 1'b0);
    end
    check("fill_accepts", 32'(n_acc), 32'd5);
    #1;
    check("full_in_ready", 32'(bus.in_ready), 32'd0);
    check("stall_valid", 32'(bus.out_valid), 32'd1);
    check("stall_data", bus.out_data, snap);
    @(negedge clk);

    // Random backpressure and bubbles
    for (int i = 0; i < 80; i++) rand_word(1'(($urandom_range(0, 3)) != 0), 1'($urandom_range(0, 1)));
    drain();
    check("conserve", 32'(n_out), 32'(n_acc));

    // Reset with three words in flight
    cycle(1'b1, ROT_LEFT, 5'd3, 32'h0000_0001, 1'b0, 32'h0000_0008);
    cycle(1'b1, ROT_LEFT, 5'd3, 32'h0000_0002, 1'b0, 32'h0000_0010);
    cycle(1'b1, ROT_LEFT, 5'd3, 32'h0000_0003, 1'b0, 32'h0000_0018);
    idle(1'b0);
    idle(1'b0);
    check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_async_valid", 32'(bus.out_valid), 32'd0);
    check("rst_async_data", bus.out_data, 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    n_out = 0;
    for (int i = 0; i < 10; i++) idle(1'b1);
    check("flushed_words", 32'(n_out), 32'd0);

    cycle(1'b1, ROT_LEFT, 5'd8, 32'hDEAD_BEEF, 1'b1, 32'hADBE_EFDE);
    drain();

    // W=8, one register stage
    bus8.in_valid = 1'b1;
    bus8.in_dir   = ROT_LEFT;
    bus8.in_amt   = 3'd3;
    bus8.in_data  = 8'hA5;
`ifdef RC6_ROT_TAG_EN
    bus8.tag_in   = 8'h5C;
`endif
    #1;
    check("w8_in_ready", 32'(bus8.in_ready), 32'd1);
    @(negedge clk);
    bus8.in_valid = 1'b0;
    check("w8_valid", 32'(bus8.out_valid), 32'd1);
    check("w8_data", 32'(bus8.out_data), 32'h2D);
`ifdef RC6_ROT_TAG_EN
    check("w8_tag", 32'(bus8.tag_out), 32'h5C);
`endif
    @(negedge clk);
    check("w8_valid_off", 32'(bus8.out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rc6_rot_pipe.md
Name: rc6_rot_pipe

Overview:
Parametrised, pipelined barrel rotator for the RC6 datapath. It rotates a W-bit word left or right by a data-dependent amount taken modulo W. The encrypt round uses left rotates; the decrypt round uses right rotates. One rotation stage is built per amount bit, with optional registers between stages, and the block has a valid/ready handshake with bubble-collapsing backpressure. It replaces the fixed 32-bit combinational left rotator in the round and key-schedule pipelines.

Parameters:
- W, 32, data word width; power of two, 8..64.
- AMT_W, $clog2(W), rotate-amount width; derived, not to be overridden.
- REG_EVERY, 1, pipeline register after every REG_EVERY rotation stages; valid range 1..AMT_W.
- TAG_W, 8, sideband tag width; used only when RC6_ROT_TAG_EN is defined.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  block accepts the input this cycle.
- in_dir  in  1  0 = rotate left, 1 = rotate right.
- in_amt  in  AMT_W  rotate amount; only the low AMT_W bits exist.
- in_data  in  W  word to rotate.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  W  rotated word.
- tag_in  in  TAG_W  sideband tag (RC6_ROT_TAG_EN only).
- tag_out  out  TAG_W  tag aligned with out_data (RC6_ROT_TAG_EN only).

Behaviour:
- One clock; reset is asynchronous and active-low.
- Function: out_data = rotl(in_data, in_amt) when dir = 0; out_data = rotr(in_data, in_amt) when dir = 1. The amount is always taken mod W, so amt = 0 is a pass-through in both directions.
- Stage k (k = 0..AMT_W-1) rotates by 2^k when its amount bit k is set.
- Right rotate uses the same stage hardware with per-stage direction; no subtraction of the amount.
- Number of register stages: NREG = ceil(AMT_W / REG_EVERY). Latency is NREG cycles from accept to out_valid. Default W=32: 5 cycles.
- Each register stage holds its valid bit, data, remaining amount bits, dir and tag.
- A stage loads when it is empty or when the next stage loads (bubble collapse). The last stage's "next loads" condition is out_ready.
- in_ready = load enable of the first register stage. It is combinational from out_ready through the valid chain; there is no combinational path from in_valid.
- Accept happens when in_valid && in_ready. When in_valid = 0 the first stage loads a bubble (valid 0).
- When out_valid = 1 and out_ready = 0: out_data, out_valid and tag_out hold stable.
- Throughput is one word per cycle with out_ready held high.
- Capacity is NREG words. in_ready goes low only when every stage is valid and out_ready = 0.
- Reset, including mid-operation: all stage valid bits clear to 0 immediately, out_valid = 0 and in_flight words are discarded. out_data and tag_out reset to 0. in_ready = 1 from the first cycle after reset release.
- Ordering: results leave in accept order; the block never drops or duplicates a word.
- Data/amt/dir/tag registers do not need reset for correctness; they are reset anyway for X-free simulation.

Optional Feature:
- Macro: RC6_ROT_TAG_EN.
- Defined: tag_in/tag_out ports exist. The tag is captured with the word on accept and presented on tag_out with its result under the same hold rules.
- Undefined: the ports and registers are absent; the rest of the behaviour is unchanged.

Decomposition:
- Package rc6_pkg:
  - ROT_LEFT = 1'b0 and ROT_RIGHT = 1'b1 constants.
  - RC6_W default constant.
  - rot_dir_t typedef.
- Sub-module rc6_rot_stage: combinational single stage, parameters W and SHIFT (2^k). Inputs: en, dir, din. Output: dout.
- Top module rc6_rot_pipe instantiates AMT_W stages via generate and inserts registers and handshake logic per REG_EVERY.

Test Plan:
- W=32, left, amt=1, din=0x80000001 -> out_data 0x00000003 after 5 cycles, out_valid pulses one cycle with out_ready=1.
- W=32, right, amt=4, din=0x12345678 -> 0x81234567. Left, amt=31, same din -> 0x091A2B3C. amt=0 in both directions -> 0x12345678.
- Back-to-back stream of 100 random words/amt/dir with out_ready=1 -> one result per cycle, each matching a reference model, in order.
- Fill, then hold out_ready=0 for 10 cycles -> in_ready low after exactly 5 accepts, outputs stable. Release, then toggle out_ready randomly -> no loss or duplication, order kept.
- Assert rst_n low for 1 cycle with 3 words in flight -> out_valid 0 at once, none of those words appear afterwards, in_ready=1 after release.
- W=8, REG_EVERY=3 (NREG=1), with RC6_ROT_TAG_EN: left amt=3, din=0xA5, tag 0x5C -> out_data 0x2D, tag_out 0x5C, latency 1 cycle.
